// File: rtl/controle_rega_nivel.sv
// rtl/controle_rega_nivel.sv - sensor conditioning, tank level classification and irrigation FSM
// feeding the 7-segment level/irrigation display driver.
module controle_rega_nivel #(
  parameter int DEB_CYCLES  = 4,
  parameter int MIN_RUN     = 8,
  parameter int DISP_PERIOD = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Sensor_Alto,
  input  logic Sensor_Medio,
  input  logic Sensor_Baixo,
  input  logic Solo_Seco,
  input  logic Temp_Alta,
  output logic Nv_Critico,
  output logic Nv_Baixo,
  output logic Nv_Medio,
  output logic Nv_Alto,
  output logic ERRO,
  output logic Bs,
  output logic Vs,
  output logic Ve,
  output logic Sd
);

  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(MIN_RUN + 1);
  localparam int PW = $clog2(DISP_PERIOD);

  typedef enum logic [1:0] {IDLE, ASPERSAO, GOTEJAMENTO, ENCHER} state_t;

  // Bit order {Alto, Medio, Baixo, Solo_Seco, Temp_Alta}
  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync2_q, deb_q;
  logic [DW-1:0] deb_cnt_q [5];

  // Flag order {Critico, Baixo, Medio, Alto, ERRO}
  logic [4:0]    lvl_q, lvl_d;
  state_t        state_q, state_d;
  logic [RW-1:0] run_cnt_q;
  logic [PW-1:0] disp_cnt_q;
  logic          bs_q, vs_q, ve_q, sd_q;
  logic          fault, drip_pref, run_ok, irrig_q, irrig_d;

  assign raw = {Sensor_Alto, Sensor_Medio, Sensor_Baixo, Solo_Seco, Temp_Alta};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lvl_d = 5'b00001;
    case (deb_q[4:2])
      3'b111:  lvl_d = 5'b00010;
      3'b011:  lvl_d = 5'b00100;
      3'b001:  lvl_d = 5'b01000;
      3'b000:  lvl_d = 5'b10000;
      default: lvl_d = 5'b00001;
    endcase
  end

  assign fault     = lvl_q[4] | lvl_q[0];
  assign drip_pref = deb_q[0] | lvl_q[3];
  assign run_ok    = (run_cnt_q >= RW'(MIN_RUN));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fault)                      state_d = ENCHER;
        else if (deb_q[1] && drip_pref) state_d = GOTEJAMENTO;
        else if (deb_q[1])              state_d = ASPERSAO;
      end
      ASPERSAO: begin
        if (fault)                      state_d = ENCHER;
        else if (run_ok && !deb_q[1])   state_d = IDLE;
        else if (run_ok && drip_pref)   state_d = GOTEJAMENTO;
      end
      GOTEJAMENTO: begin
        if (fault)                      state_d = ENCHER;
        else if (run_ok && !deb_q[1])   state_d = IDLE;
        else if (run_ok && !drip_pref)  state_d = ASPERSAO;
      end
      ENCHER: begin
        if (lvl_q[1])                   state_d = IDLE;
      end
      default:                          state_d = IDLE;
    endcase
  end

  assign irrig_q = (state_q == ASPERSAO) || (state_q == GOTEJAMENTO);
  assign irrig_d = (state_d == ASPERSAO) || (state_d == GOTEJAMENTO);

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      lvl_q      <= 5'b10000;
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      disp_cnt_q <= '0;
      bs_q       <= 1'b0;
      vs_q       <= 1'b0;
      ve_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      state_q <= state_d;
      bs_q    <= (state_d == ASPERSAO);
      vs_q    <= (state_d == GOTEJAMENTO);
      ve_q    <= (state_d == ENCHER) && !lvl_q[0];
      if (state_d != state_q) run_cnt_q <= '0;
      else if (!run_ok)       run_cnt_q <= run_cnt_q + 1'b1;
      // Sprinkler<->drip moves keep the display phase running.
      if (irrig_d && irrig_q) begin
        if (disp_cnt_q == PW'(DISP_PERIOD - 1)) begin
          disp_cnt_q <= '0;
          sd_q       <= ~sd_q;
        end else begin
          disp_cnt_q <= disp_cnt_q + 1'b1;
        end
      end else begin
        disp_cnt_q <= '0;
        sd_q       <= 1'b0;
      end
    end
  end

  assign {Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto, ERRO} = lvl_q;
  assign Bs = bs_q;
  assign Vs = vs_q;
  assign Ve = ve_q;
  assign Sd = sd_q;

endmodule

// File: tb/tb_controle_rega_nivel.sv
// tb/tb_controle_rega_nivel.sv - scoreboard bench with a history-based reference model.
module tb_controle_rega_nivel;
  localparam int DEB  = 4;
  localparam int MINR = 8;
  localparam int DISP = 16;
  localparam int S_IDLE = 0, S_ASP = 1, S_GOT = 2, S_ENC = 3;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic sa = 1'b0, sm = 1'b0, sb = 1'b0, ss = 1'b0, ta = 1'b0;
  logic nv_c, nv_b, nv_m, nv_a, erro, bs, vs, ve, sd;

  always #5 Clk = ~Clk;

  controle_rega_nivel #(.DEB_CYCLES(DEB), .MIN_RUN(MINR), .DISP_PERIOD(DISP)) dut (
    .Clk(Clk), .Rst(Rst),
    .Sensor_Alto(sa), .Sensor_Medio(sm), .Sensor_Baixo(sb),
    .Solo_Seco(ss), .Temp_Alta(ta),
    .Nv_Critico(nv_c), .Nv_Baixo(nv_b), .Nv_Medio(nv_m), .Nv_Alto(nv_a), .ERRO(erro),
    .Bs(bs), .Vs(vs), .Ve(ve), .Sd(sd)
  );

  logic [8:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: raw sample history {A,M,B,Solo,Temp}, flags {Crit,Baixo,Medio,Alto,ERRO}
  logic [4:0] hist[$];
  logic [4:0] m_deb = '0;
  logic [4:0] m_lvl = 5'b10000;
  int         m_st = S_IDLE, m_age = 0, m_irr = 0;
  logic       m_bs = 0, m_vs = 0, m_ve = 0, m_sd = 0;

  function automatic logic [4:0] classify(input logic [2:0] amb);
    case (amb)
      3'b111:  return 5'b00010;
      3'b011:  return 5'b00100;
      3'b001:  return 5'b01000;
      3'b000:  return 5'b10000;
      default: return 5'b00001;
    endcase
  endfunction

  function automatic bit is_irr(input int s);
    return (s == S_ASP) || (s == S_GOT);
  endfunction

  task automatic model_step();
    logic [4:0] raw_now, new_deb, new_lvl, h;
    logic fault, drip, solo, ok, flip;
    int nst;
    raw_now = {sa, sm, sb, ss, ta};
    if (Rst) begin
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
      m_deb = '0; m_lvl = 5'b10000; m_st = S_IDLE; m_age = 0; m_irr = 0;
      m_bs = 0; m_vs = 0; m_ve = 0; m_sd = 0;
    end else begin
      new_lvl = classify(m_deb[4:2]);
      // A debounced bit flips once the value seen two cycles late has disagreed DEB times running.
      new_deb = m_deb;
      for (int b = 0; b < 5; b++) begin
        flip = 1'b1;
        for (int k = 1; k <= DEB; k++) begin
          h = hist[k];
          if (h[b] == m_deb[b]) flip = 1'b0;
        end
        if (flip) new_deb[b] = ~m_deb[b];
      end
      hist.push_front(raw_now);
      void'(hist.pop_back());
      fault = m_lvl[4] | m_lvl[0];
      drip  = m_deb[0] | m_lvl[3];
      solo  = m_deb[1];
      ok    = (m_age >= MINR);
      nst = m_st;
      case (m_st)
        S_IDLE: if (fault) nst = S_ENC; else if (solo && drip) nst = S_GOT; else if (solo) nst = S_ASP;
        S_ASP:  if (fault) nst = S_ENC; else if (ok && !solo) nst = S_IDLE; else if (ok && drip) nst = S_GOT;
        S_GOT:  if (fault) nst = S_ENC; else if (ok && !solo) nst = S_IDLE; else if (ok && !drip) nst = S_ASP;
        default: if (m_lvl[1]) nst = S_IDLE;
      endcase
      m_age = (nst != m_st) ? 0 : m_age + 1;
      m_irr = (is_irr(nst) && is_irr(m_st)) ? m_irr + 1 : 0;
      m_sd  = ((m_irr / DISP) % 2) == 1;
      m_bs  = (nst == S_ASP);
      m_vs  = (nst == S_GOT);
      m_ve  = (nst == S_ENC) && !m_lvl[0];
      m_deb = new_deb;
      m_lvl = new_lvl;
      m_st  = nst;
    end
    exp_q.push_back({m_lvl, m_bs, m_vs, m_ve, m_sd});
  endtask

  task automatic step();
    @(posedge Clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic set_amb(input logic [2:0] amb);
    {sa, sm, sb} = amb;
  endtask

  always @(negedge Clk) begin
    logic [8:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {nv_c, nv_b, nv_m, nv_a, erro, bs, vs, ve, sd};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cyc %0d: got {lvl,Bs,Vs,Ve,Sd}=%b required %b", cyc, a, e);
      n_total++;
      if ($onehot({nv_c, nv_b, nv_m, nv_a, erro}) && !(bs && vs) && !(bs && ve) && !(vs && ve)) n_pass++;
      else $display("FAIL exclusivity cyc %0d: got flags=%b Bs/Vs/Ve=%b required one-hot flags, one actuator", cyc, a[8:4], a[3:1]);
    end
  end

  initial begin
    logic [4:0] v;
    int r, nbit, glen;
    for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
    Rst = 1'b1;
    hold(3);
    Rst = 1'b0;
    hold(6);
    set_amb(3'b111);
    hold(12);
    ss = 1'b1; ta = 1'b0;
    hold(40);
    ss = 1'b0;
    hold(16);
    ss = 1'b1;
    hold(9);
    ta = 1'b1;
    hold(24);
    set_amb(3'b100);
    hold(12);
    set_amb(3'b111);
    hold(14);
    hold(10);
    sb = 1'b0;
    hold(2);
    sb = 1'b1;
    hold(10);
    Rst = 1'b1;
    hold(1);
    Rst = 1'b0;
    ss = 1'b0; ta = 1'b0;
    hold(12);

    for (int seg = 0; seg < 250; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        Rst = 1'b1;
        step();
        Rst = 1'b0;
      end
      case ($urandom_range(0, 9))
        0, 1:    set_amb(3'b000);
        2, 3:    set_amb(3'b001);
        4, 5:    set_amb(3'b011);
        6, 7, 8: set_amb(3'b111);
        default: set_amb(3'($urandom_range(0, 7)));
      endcase
      ss = 1'($urandom_range(0, 1));
      ta = 1'($urandom_range(0, 1));
      if (r >= 3 && r < 15) begin
        hold($urandom_range(1, 10));
        v = {sa, sm, sb, ss, ta};
        nbit = $urandom_range(0, 4);
        glen = $urandom_range(1, DEB - 1);
        v[nbit] = ~v[nbit];
        {sa, sm, sb, ss, ta} = v;
        hold(glen);
        v[nbit] = ~v[nbit];
        {sa, sm, sb, ss, ta} = v;
      end
      hold($urandom_range(1, 30));
    end

    @(negedge Clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
